// File: rtl/cpu_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for the RV32I core.
// Drives datapath strobes and mux selects from the state and the opcode latched in DECODE.
module cpu_control_fsm #(
    parameter int unsigned ACK_TIMEOUT     = 16,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] ir_opcode,
    input  logic [2:0] ir_funct3,
    input  logic       branch_taken,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       alu_a_sel,
    output logic       alu_b_sel,
    output logic [1:0] alu_op_sel,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       instr_retired,
    output logic       fault,
    output logic [1:0] fault_cause
);

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

    typedef enum logic [2:0] {
        F3_BYTE  = 3'b000,
        F3_HALF  = 3'b001,
        F3_WORD  = 3'b010
    } funct3_e;

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_FAULT
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_IMEM    = 2'd2,
        CAUSE_DMEM    = 2'd3
    } cause_e;

    localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    state_e          state;
    opcode_e         opc_q;
    cause_e          cause_q;
    logic [CW-1:0]   cnt;

    opcode_e         opc_in;
    logic            known_opc;
    logic            illegal;
    logic            nop_decode;
    logic            ack_last;
    logic            is_ls;
    logic            sel_a;
    logic            sel_b;
    logic [1:0]      sel_op;

    // Decode of the raw IR opcode; only meaningful while in DECODE.
    always_comb begin
        opc_in    = opcode_e'(ir_opcode);
        known_opc = 1'b0;
        case (opc_in)
            OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
            OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: known_opc = 1'b1;
            default:                                            known_opc = 1'b0;
        endcase
        illegal = !known_opc ||
                  (((opc_in == OPC_LOAD) || (opc_in == OPC_STORE)) &&
                   (funct3_e'(ir_funct3) != F3_WORD));
        nop_decode = (known_opc && ((opc_in == OPC_MISC_MEM) || (opc_in == OPC_SYSTEM)) && !illegal) ||
                     (illegal && !TRAP_ON_ILLEGAL);
    end

    // Final allowed wait cycle; an ack in this cycle still wins.
    always_comb begin
        ack_last = (ACK_TIMEOUT != 0) && (cnt == CW'(ACK_TIMEOUT - 1));
    end

    always_comb begin
        is_ls  = (opc_q == OPC_LOAD) || (opc_q == OPC_STORE);
        sel_a  = 1'b0;
        sel_b  = 1'b0;
        sel_op = 2'd0;
        case (opc_q)
            OPC_OP:     sel_op = 2'd1;
            OPC_OP_IMM: begin sel_b = 1'b1; sel_op = 2'd1; end
            OPC_LUI:    begin sel_b = 1'b1; sel_op = 2'd2; end
            OPC_AUIPC:  begin sel_a = 1'b1; sel_b = 1'b1; end
            OPC_LOAD,
            OPC_STORE:  sel_b = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_RESET;
            opc_q   <= OPC_OP;
            cause_q <= CAUSE_NONE;
            cnt     <= '0;
        end else begin
            case (state)
                S_RESET: begin
                    state <= S_FETCH;
                    cnt   <= '0;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        state <= S_DECODE;
                    end else if (ack_last) begin
                        state   <= S_FAULT;
                        cause_q <= CAUSE_IMEM;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    opc_q <= opc_in;
                    if (illegal && TRAP_ON_ILLEGAL) begin
                        state   <= S_FAULT;
                        cause_q <= CAUSE_ILLEGAL;
                    end else if (nop_decode) begin
                        state <= S_FETCH;
                        cnt   <= '0;
                    end else begin
                        state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (opc_q == OPC_BRANCH) begin
                        state <= S_FETCH;
                        cnt   <= '0;
                    end else if (is_ls) begin
                        state <= S_MEM;
                        cnt   <= '0;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (opc_q == OPC_STORE) begin
                            state <= S_FETCH;
                            cnt   <= '0;
                        end else begin
                            state <= S_WB;
                        end
                    end else if (ack_last) begin
                        state   <= S_FAULT;
                        cause_q <= CAUSE_DMEM;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WB: begin
                    state <= S_FETCH;
                    cnt   <= '0;
                end
                S_FAULT: state <= S_FAULT;
                default: state <= S_RESET;
            endcase
        end
    end

    always_comb begin
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_sel        = 2'd0;
        alu_a_sel     = 1'b0;
        alu_b_sel     = 1'b0;
        alu_op_sel    = 2'd0;
        reg_we        = 1'b0;
        wb_sel        = 2'd0;
        instr_retired = 1'b0;
        fault         = (state == S_FAULT);
        fault_cause   = cause_q;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ack;
            end
            S_DECODE: begin
                if (nop_decode) begin
                    pc_we         = 1'b1;
                    instr_retired = 1'b1;
                end
            end
            S_EXECUTE: begin
                alu_a_sel  = sel_a;
                alu_b_sel  = sel_b;
                alu_op_sel = sel_op;
                if (opc_q == OPC_BRANCH) begin
                    pc_we         = 1'b1;
                    pc_sel        = branch_taken ? 2'd1 : 2'd0;
                    instr_retired = 1'b1;
                end
            end
            S_MEM: begin
                alu_a_sel  = sel_a;
                alu_b_sel  = sel_b;
                alu_op_sel = sel_op;
                dmem_req   = 1'b1;
                dmem_we    = (opc_q == OPC_STORE);
                if (dmem_ack && (opc_q == OPC_STORE)) begin
                    pc_we         = 1'b1;
                    instr_retired = 1'b1;
                end
            end
            S_WB: begin
                reg_we        = 1'b1;
                pc_we         = 1'b1;
                instr_retired = 1'b1;
                case (opc_q)
                    OPC_LOAD: wb_sel = 2'd1;
                    OPC_JAL:  begin wb_sel = 2'd2; pc_sel = 2'd1; end
                    OPC_JALR: begin wb_sel = 2'd2; pc_sel = 2'd2; end
                    default:  ;
                endcase
            end
            default: ;
        endcase
    end

endmodule
